// File: rtl/beep_cadence_driver.sv
// beep_cadence_driver: square-wave buzzer tone gated into timed on/off bursts.
// Every output comes straight from a flop, so the buzzer pin is glitch-free.
module beep_cadence_driver #(
    parameter int HALF_PERIOD = 12500,
    parameter int ON_CYCLES   = 10000000,
    parameter int OFF_CYCLES  = 10000000,
    parameter int BURSTS      = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic beep_en,
    output logic beep,
    output logic busy,
    output logic done
);
    localparam int PMAX = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
    localparam int PW   = PMAX > 1 ? $clog2(PMAX) : 1;
    localparam int BW   = BURSTS > 0 ? $clog2(BURSTS + 1) : 1;
    localparam logic [TW-1:0] TONE_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_CYCLES - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURSTS);

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t        state_q;
    logic [TW-1:0] tone_q;
    logic [PW-1:0] phase_q;
    logic [BW-1:0] burst_q;
    logic          beep_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tone_q  <= '0;
            phase_q <= '0;
            burst_q <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if ((state_q == ON || state_q == OFF) && !beep_en) begin
            // abort wins over any coincident tone or phase event
            state_q <= IDLE;
            tone_q  <= '0;
            phase_q <= '0;
            burst_q <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (beep_en) begin
                    state_q <= ON;
                    tone_q  <= '0;
                    phase_q <= '0;
                    burst_q <= BW'(1);
                    beep_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                ON: if (phase_q == ON_LAST) begin
                    tone_q  <= '0;
                    phase_q <= '0;
                    beep_q  <= 1'b0;
                    if (BURSTS != 0 && burst_q == BURST_LAST) begin
                        state_q <= DONE;
                        burst_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= OFF;
                    end
                end else begin
                    phase_q <= phase_q + 1'b1;
                    tone_q  <= tone_q == TONE_LAST ? '0 : tone_q + 1'b1;
                    beep_q  <= tone_q == TONE_LAST ? ~beep_q : beep_q;
                end
                OFF: if (phase_q == OFF_LAST) begin
                    // each burst restarts high with a fresh tone phase
                    state_q <= ON;
                    tone_q  <= '0;
                    phase_q <= '0;
                    burst_q <= burst_q == '1 ? burst_q : burst_q + 1'b1;
                    beep_q  <= 1'b1;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
                DONE: if (!beep_en) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beep = beep_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
